// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with synchronizer, press/release debounce
// and a one-cycle key_valid strobe. Define KEYPAD_AUTOREPEAT_EN for auto-repeat while held.
module keypad_scan #(
    parameter int SCAN_DIV     = 48000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_CNT   = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_n;
    logic [1:0]    row, row_n;
    logic [1:0]    col, col_n;
    logic [SW-1:0] scan_cnt, scan_cnt_n;
    logic [DW-1:0] db_cnt, db_cnt_n;
    logic [3:0]    key_n;
    logic          key_valid_n;
    logic [3:0]    sync1, scols;
    logic          col_low;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    logic [RW-1:0] rep_cnt, rep_cnt_n;
`endif

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:  key_code = 4'h1;
            4'd1:  key_code = 4'h2;
            4'd2:  key_code = 4'h3;
            4'd3:  key_code = 4'hA;
            4'd4:  key_code = 4'h4;
            4'd5:  key_code = 4'h5;
            4'd6:  key_code = 4'h6;
            4'd7:  key_code = 4'hB;
            4'd8:  key_code = 4'h7;
            4'd9:  key_code = 4'h8;
            4'd10: key_code = 4'h9;
            4'd11: key_code = 4'hC;
            4'd12: key_code = 4'hE;
            4'd13: key_code = 4'h0;
            4'd14: key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    function automatic logic [1:0] first_low(input logic [3:0] v);
        if (!v[0])      first_low = 2'd0;
        else if (!v[1]) first_low = 2'd1;
        else if (!v[2]) first_low = 2'd2;
        else            first_low = 2'd3;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 4'b1111;
            scols <= 4'b1111;
        end else begin
            sync1 <= cols;
            scols <= sync1;
        end
    end

    assign col_low = ~scols[col];
    assign rows    = ~(4'b0001 << row);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            row       <= row_n;
            col       <= col_n;
            scan_cnt  <= scan_cnt_n;
            db_cnt    <= db_cnt_n;
            key       <= key_n;
            key_valid <= key_valid_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= rep_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        row_n       = row;
        col_n       = col;
        scan_cnt_n  = scan_cnt;
        db_cnt_n    = db_cnt;
        key_n       = key;
        key_valid_n = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_n   = rep_cnt;
`endif
        case (state)
            SCAN: begin
                if (scan_cnt >= SW'(SCAN_DIV - 1)) begin
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                    if (scols != 4'b1111) begin
                        col_n   = first_low(scols);
                        state_n = DEBOUNCE;
                    end else begin
                        row_n = row + 2'd1;
                    end
                end else if (scan_cnt != SW'(SCAN_DIV)) begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_low) begin
                    if (db_cnt >= DW'(DEBOUNCE_CNT - 1)) begin
                        key_n       = key_code(row, col);
                        key_valid_n = 1'b1;
                        db_cnt_n    = '0;
                        state_n     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_n   = '0;
`endif
                    end else if (db_cnt != DW'(DEBOUNCE_CNT)) begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end else begin
                    // bounce: drop the candidate and move on as if the row were empty
                    state_n    = SCAN;
                    row_n      = row + 2'd1;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                end
            end
            HELD: begin
                if (!col_low) begin
                    state_n  = RELEASE;
                    db_cnt_n = '0;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_cnt >= RW'(REPEAT_CNT - 1)) begin
                        key_valid_n = 1'b1;
                        rep_cnt_n   = '0;
                    end else if (rep_cnt != RW'(REPEAT_CNT)) begin
                        rep_cnt_n = rep_cnt + 1'b1;
                    end
`endif
                end
            end
            RELEASE: begin
                if (col_low) begin
                    db_cnt_n = '0;
                end else if (db_cnt >= DW'(DEBOUNCE_CNT - 1)) begin
                    state_n    = SCAN;
                    row_n      = row + 2'd1;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                end else if (db_cnt != DW'(DEBOUNCE_CNT)) begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a behavioural keypad matrix drives cols from rows; pulses are
// logged with their cycle number and compared against the key map and timing rules.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key;
    logic       key_valid;

    logic [15:0] pressed = '0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pt[$];
    logic [3:0]  pk[$];
    logic        prev_kv = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_CNT(8)) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key(key), .key_valid(key_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (reset && key_valid) begin
            pt.push_back(cyc);
            pk.push_back(key);
            tests++;
            if (prev_kv) begin
                fails++;
                $display("FAIL kv_consecutive: key_valid high at cycles %0d and %0d, required single-cycle", cyc - 1, cyc);
            end
        end
        prev_kv = reset && key_valid;
    end

    function automatic logic [3:0] exp_key(input int idx);
        string m;
        byte   ch;
        m  = "123A456B789CE0FD";
        ch = m.getc(idx);
        if (ch >= "A") exp_key = 4'(ch - "A" + 10);
        else           exp_key = 4'(ch - "0");
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        pt.delete();
        pk.delete();
    endtask

    task automatic wait_pulse(input string name, input int n0);
        int i = 0;
        while (pt.size() <= n0 && i < 150) begin
            step(1);
            i++;
        end
        tests++;
        if (pt.size() <= n0) begin
            fails++;
            $display("FAIL %s_timeout: pulses seen %0d, required > %0d", name, pt.size(), n0);
        end
    endtask

    task automatic wait_row_start(input logic [3:0] target);
        logic [3:0] prev;
        int i = 0;
        bit found = 0;
        while (!found && i < 100) begin
            prev = rows;
            step(1);
            if (rows == target && prev != target) found = 1;
            i++;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL row_start_timeout: rows=%b, required edge into %b", rows, target);
        end
    endtask

    task automatic test_reset();
        logic [3:0] er;
        reset = 1'b0;
        pressed = '0;
        step(2);
        tests += 3;
        if (rows !== 4'b1110) begin fails++; $display("FAIL reset_rows: got %b, required 1110", rows); end
        if (key !== 4'h0) begin fails++; $display("FAIL reset_key: got %h, required 0", key); end
        if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_kv: got %b, required 0", key_valid); end
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step(1);
            er = ~(4'b0001 << ((k / 4) % 4));
            tests++;
            if (rows !== er) begin
                fails++;
                $display("FAIL scan_rotation[%0d]: rows=%b, required %b", k, rows, er);
            end
        end
    endtask

    task automatic test_held_key5();
        bit frozen = 1;
        int i = 0;
        clear_q();
        pressed[5] = 1'b1;
        wait_pulse("key5", 0);
        tests++;
        if (key !== 4'h5) begin fails++; $display("FAIL key5_value: got %h, required 5", key); end
        for (int j = 0; j < 40; j++) begin
            step(1);
            if (rows !== 4'b1101) frozen = 0;
        end
        tests++;
        if (!frozen) begin fails++; $display("FAIL key5_frozen: rows left 1101 (now %b), required 1101 while held", rows); end
        pressed = '0;
        while (rows === 4'b1101 && i < 30) begin step(1); i++; end
        tests++;
        if (rows !== 4'b1011) begin fails++; $display("FAIL key5_next_row: got %b, required 1011", rows); end
`ifndef KEYPAD_AUTOREPEAT_EN
        tests++;
        if (pt.size() != 1) begin fails++; $display("FAIL key5_count: got %0d pulses, required 1", pt.size()); end
`endif
        foreach (pk[j]) begin
            tests++;
            if (pk[j] !== 4'h5) begin fails++; $display("FAIL key5_pulse_key[%0d]: got %h, required 5", j, pk[j]); end
        end
    endtask

    task automatic test_bounce();
        clear_q();
        wait_row_start(4'b1110);
        pressed[2] = 1'b1;
        step(4);
        pressed = '0;
        step(3);
        tests++;
        if (rows !== 4'b1101) begin fails++; $display("FAIL bounce_resume_row: got %b, required 1101", rows); end
        step(10);
        tests += 2;
        if (pt.size() != 0) begin fails++; $display("FAIL bounce_pulse: got %0d pulses, required 0", pt.size()); end
        if (key !== 4'h5) begin fails++; $display("FAIL bounce_key: got %h, required 5", key); end
    endtask

    task automatic test_two_cols();
        clear_q();
        pressed[1] = 1'b1;
        pressed[3] = 1'b1;
        wait_pulse("two_cols", 0);
        step(3);
        pressed = '0;
        step(20);
        tests += 2;
        if (pk.size() == 0 || pk[0] !== 4'h2) begin fails++; $display("FAIL two_cols_key: got %h, required 2", key); end
        if (pt.size() != 1) begin fails++; $display("FAIL two_cols_count: got %0d pulses, required 1", pt.size()); end
    endtask

    task automatic test_no_rollover();
        int n_d = 0, n_1 = 0;
        clear_q();
        pressed[0] = 1'b1;
        wait_pulse("rollover_1", 0);
        pressed[15] = 1'b1;
        step(40);
        foreach (pk[j]) if (pk[j] === 4'hD) n_d++; else if (pk[j] === 4'h1) n_1++;
        tests++;
        if (n_d != 0) begin fails++; $display("FAIL rollover_early_d: got %0d D pulses, required 0", n_d); end
`ifndef KEYPAD_AUTOREPEAT_EN
        tests++;
        if (n_1 != 1) begin fails++; $display("FAIL rollover_one_count: got %0d pulses of 1, required 1", n_1); end
`endif
        pressed[0] = 1'b0;
        wait_pulse("rollover_d", pt.size());
        pressed = '0;
        step(20);
        n_d = 0;
        foreach (pk[j]) if (pk[j] === 4'hD) n_d++;
        tests += 2;
        if (n_d != 1) begin fails++; $display("FAIL rollover_d_count: got %0d D pulses, required 1", n_d); end
        if (key !== 4'hD) begin fails++; $display("FAIL rollover_d_key: got %h, required D", key); end
    endtask

    task automatic test_autorepeat();
        int t0, i = 0;
        int exp_t[$];
        clear_q();
        pressed[13] = 1'b1;
        wait_pulse("repeat", 0);
        t0 = (pt.size() > 0) ? pt[0] : cyc;
        while (cyc < t0 + 28 && i < 60) begin step(1); i++; end
        pressed = '0;
        step(20);
        exp_t.push_back(t0);
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int k = 1; k <= 3; k++) exp_t.push_back(t0 + 8 * k);
`endif
        tests++;
        if (pt.size() != exp_t.size()) begin
            fails++;
            $display("FAIL repeat_count: got %0d pulses, required %0d", pt.size(), exp_t.size());
        end else begin
            foreach (exp_t[j]) begin
                tests += 2;
                if (pt[j] != exp_t[j]) begin fails++; $display("FAIL repeat_time[%0d]: got cycle %0d, required %0d", j, pt[j], exp_t[j]); end
                if (pk[j] !== 4'h0) begin fails++; $display("FAIL repeat_key[%0d]: got %h, required 0", j, pk[j]); end
            end
        end
    endtask

    task automatic test_random_keys();
        int order[16];
        int tmp, j;
        logic [3:0] ek;
        for (int k = 0; k < 16; k++) order[k] = k;
        for (int k = 15; k > 0; k--) begin
            j = int'($urandom_range(k, 0));
            tmp = order[k]; order[k] = order[j]; order[j] = tmp;
        end
        for (int k = 0; k < 16; k++) begin
            clear_q();
            ek = exp_key(order[k]);
            pressed[order[k]] = 1'b1;
            step(int'($urandom_range(70, 45)));
            pressed = '0;
            step(25);
            tests += 2;
            if (pk.size() == 0 || pk[0] !== ek) begin
                fails++;
                $display("FAIL random_key[%0d]: pos %0d got %h (%0d pulses), required %h", k, order[k], key, pk.size(), ek);
            end
            if (key !== ek) begin fails++; $display("FAIL random_hold[%0d]: key=%h, required %h", k, key, ek); end
`ifdef KEYPAD_AUTOREPEAT_EN
            for (int m = 1; m < pt.size(); m++) begin
                tests++;
                if (pt[m] - pt[m-1] != 8 || pk[m] !== ek) begin
                    fails++;
                    $display("FAIL random_repeat[%0d]: gap %0d key %h, required 8 and %h", k, pt[m] - pt[m-1], pk[m], ek);
                end
            end
`else
            tests++;
            if (pt.size() != 1) begin fails++; $display("FAIL random_count[%0d]: got %0d pulses, required 1", k, pt.size()); end
`endif
        end
    endtask

    task automatic test_reset_mid_press();
        clear_q();
        pressed[8] = 1'b1;
        wait_pulse("midreset_first", 0);
        reset = 1'b0;
        step(2);
        tests += 2;
        if (key !== 4'h0) begin fails++; $display("FAIL midreset_key: got %h, required 0", key); end
        if (rows !== 4'b1110) begin fails++; $display("FAIL midreset_rows: got %b, required 1110", rows); end
        reset = 1'b1;
        clear_q();
        wait_pulse("midreset_fresh", 0);
        tests++;
        if (pk.size() == 0 || pk[0] !== 4'h7) begin fails++; $display("FAIL midreset_fresh_key: got %h, required 7", key); end
        pressed = '0;
        step(20);
    endtask

    initial begin
        test_reset();
        test_held_key5();
        test_bounce();
        test_two_cols();
        test_no_rollover();
        test_autorepeat();
        test_random_keys();
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
